// File: rtl/cent_input_ctl.sv
// Player-input sequencer: debounces the board buttons and drives the active-low
// coin/start/fire inputs, with an auto-play FSM for unattended coin/start/autofire.
module cent_input_ctl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 12000,
    parameter int unsigned PULSE_CYCLES     = 600000,
    parameter int unsigned AUTO_WAIT_CYCLES = 24000000,
    parameter int unsigned FIRE_HALF_CYCLES = 1200000
) (
    input  logic       clk12m,
    input  logic       reset_n,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       auto_en,
    output logic [9:0] playerinput_o,
    output logic [2:0] auto_state_o,
    output logic       busy_o
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned WW = (AUTO_WAIT_CYCLES > 1) ? $clog2(AUTO_WAIT_CYCLES) : 1;
    localparam int unsigned FW = (FIRE_HALF_CYCLES > 1) ? $clog2(FIRE_HALF_CYCLES) : 1;

    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);
    localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(AUTO_WAIT_CYCLES - 1);
    localparam logic [FW-1:0] FIRE_LAST  = FW'(FIRE_HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COIN  = 3'd1,
        S_WAIT  = 3'd2,
        S_START = 3'd3,
        S_PLAY  = 3'd4
    } state_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    w_stable;
    logic [2:0]    r_stable_d;
    logic [2:0]    w_press;
    logic          w_auto;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_fsm_coin_req;
    logic          w_fsm_start_req;
    logic [PW-1:0] r_coin_cnt;
    logic [PW-1:0] r_start_cnt;
    logic          w_coin_act;
    logic          w_start_act;
    logic [WW-1:0] r_wait_cnt;
    logic [FW-1:0] r_fire_cnt;
    logic          r_toggle;
    logic [9:0]    r_pi;
    logic          r_busy;

    // Assertion is immediate; release is aligned to clk12m before reaching any state.
    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_raw = {auto_en, button3, button2, button1};

    always_ff @(posedge clk12m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_stable_d <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= w_stable[2:0];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_db
        logic [DW-1:0] r_cnt;
        logic          r_st;
        always_ff @(posedge clk12m or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_cnt <= '0;
                r_st  <= 1'b0;
            end else if (r_sync2[g] == r_st) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                r_st  <= r_sync2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign w_stable[g] = r_st;
    end

    assign w_press     = w_stable[2:0] & ~r_stable_d;
    assign w_auto      = w_stable[3];
    assign w_coin_act  = (r_coin_cnt != '0);
    assign w_start_act = (r_start_cnt != '0);

    // Pulse-done advances on the last active count so the state and the pulse
    // end together; also covers a request swallowed by an already-ending pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_fsm_coin_req  = 1'b0;
        w_fsm_start_req = 1'b0;
        if (!w_auto) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt    = S_COIN;
                    w_fsm_coin_req = 1'b1;
                end
                S_COIN:  if (r_coin_cnt <= PULSE_ONE) w_state_nxt = S_WAIT;
                S_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt     = S_START;
                        w_fsm_start_req = 1'b1;
                    end
                end
                S_START: if (r_start_cnt <= PULSE_ONE) w_state_nxt = S_PLAY;
                S_PLAY:  w_state_nxt = S_PLAY;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk12m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_coin_cnt  <= '0;
            r_start_cnt <= '0;
            r_wait_cnt  <= '0;
            r_fire_cnt  <= '0;
            r_toggle    <= 1'b0;
            r_pi        <= 10'h3DF;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_coin_act)                       r_coin_cnt <= r_coin_cnt - 1'b1;
            else if (w_press[0] | w_fsm_coin_req) r_coin_cnt <= PULSE_LOAD;

            if (w_start_act)                        r_start_cnt <= r_start_cnt - 1'b1;
            else if (w_press[1] | w_fsm_start_req)  r_start_cnt <= PULSE_LOAD;

            if (r_state == S_WAIT && w_state_nxt == S_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                                            r_wait_cnt <= '0;

            if (r_state == S_PLAY && w_state_nxt == S_PLAY) begin
                if (r_fire_cnt == FIRE_LAST) begin
                    r_fire_cnt <= '0;
                    r_toggle   <= ~r_toggle;
                end else begin
                    r_fire_cnt <= r_fire_cnt + 1'b1;
                end
            end else begin
                r_fire_cnt <= '0;
                r_toggle   <= 1'b0;
            end

            r_pi <= {1'b1, 1'b1, ~w_coin_act, 1'b1, 1'b0, 1'b1, ~w_start_act, 1'b1, 1'b1,
                     ~(w_stable[2] | (r_state == S_PLAY && !r_toggle))};
            r_busy <= w_coin_act | w_start_act;
        end
    end

    assign playerinput_o = r_pi;
    assign auto_state_o  = r_state;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_cent_input_ctl.sv
// Scoreboard bench for cent_input_ctl: stimulus queues the expected output
// changes with their cycle numbers; a negedge monitor pops one per observed change.
module tb_cent_input_ctl;

    logic       clk12m = 1'b0;
    logic       reset_n = 1'b1;
    logic       button1 = 1'b0;
    logic       button2 = 1'b0;
    logic       button3 = 1'b0;
    logic       auto_en = 1'b0;
    logic [9:0] playerinput_o;
    logic [2:0] auto_state_o;
    logic       busy_o;

    localparam logic [9:0] P_IDLE  = 10'h3DF;
    localparam logic [9:0] P_COIN  = 10'h35F;
    localparam logic [9:0] P_START = 10'h3D7;
    localparam logic [9:0] P_FIRE  = 10'h3DE;

    typedef struct {
        int         cyc;
        logic [9:0] pi;
        logic [2:0] st;
        logic       b;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t;

    cent_input_ctl #(
        .DEBOUNCE_CYCLES (4),
        .PULSE_CYCLES    (10),
        .AUTO_WAIT_CYCLES(20),
        .FIRE_HALF_CYCLES(5)
    ) dut (
        .clk12m       (clk12m),
        .reset_n      (reset_n),
        .button1      (button1),
        .button2      (button2),
        .button3      (button3),
        .auto_en      (auto_en),
        .playerinput_o(playerinput_o),
        .auto_state_o (auto_state_o),
        .busy_o       (busy_o)
    );

    always #5 clk12m = ~clk12m;
    always @(posedge clk12m) cyc <= cyc + 1;

    task automatic push_exp(input int c, input logic [9:0] p, input logic [2:0] s, input logic b);
        exp_t e;
        e.cyc = c;
        e.pi  = p;
        e.st  = s;
        e.b   = b;
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk12m);
            #2;
        end
    endtask

    // Monitor: every change of the observed outputs consumes one expected event.
    logic [13:0] prev;
    logic [13:0] cur;
    bit          started = 0;
    int          evn = 0;
    always @(negedge clk12m) begin
        exp_t e;
        cur = {playerinput_o, auto_state_o, busy_o};
        if (!started || cur !== prev) begin
            started = 1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d: got pi=%h st=%0d busy=%b, required no change",
                         cyc, playerinput_o, auto_state_o, busy_o);
            end else begin
                e = q.pop_front();
                if ((e.cyc >= 0 && e.cyc != cyc) || cur !== {e.pi, e.st, e.b}) begin
                    errors++;
                    $display("FAIL event%0d cyc=%0d: got pi=%h st=%0d busy=%b, required pi=%h st=%0d busy=%b at cyc %0d",
                             evn, cyc, playerinput_o, auto_state_o, busy_o, e.pi, e.st, e.b, e.cyc);
                end
            end
            evn++;
            prev = cur;
        end
    end

    initial begin
        logic [3:0] rnd;
        #1 reset_n = 1'b0;
        push_exp(-1, P_IDLE, 3'd0, 1'b0);

        // reset held while inputs toggle: no output may move
        repeat (8) begin
            @(posedge clk12m);
            #2;
            rnd = 4'($urandom);
            {auto_en, button3, button2, button1} = rnd;
        end
        {auto_en, button3, button2, button1} = 4'b0000;
        @(posedge clk12m);
        #2;
        reset_n = 1'b1;
        wait_until(cyc + 5);

        // 3-cycle glitch on button1
        t = cyc;
        button1 = 1'b1;
        wait_until(t + 3);
        button1 = 1'b0;
        wait_until(t + 12);

        // clean coin press
        t = cyc;
        push_exp(t + 8,  P_COIN, 3'd0, 1'b1);
        push_exp(t + 18, P_IDLE, 3'd0, 1'b0);
        button1 = 1'b1;
        wait_until(t + 20);
        button1 = 1'b0;
        wait_until(t + 30);

        // second start press while the first pulse is active
        t = cyc;
        push_exp(t + 8,  P_START, 3'd0, 1'b1);
        push_exp(t + 18, P_IDLE,  3'd0, 1'b0);
        button2 = 1'b1;
        wait_until(t + 4);
        button2 = 1'b0;
        wait_until(t + 8);
        button2 = 1'b1;
        wait_until(t + 12);
        button2 = 1'b0;
        wait_until(t + 30);

        // full auto sequence, button3 held in PLAY, then abort from PLAY
        t = cyc;
        push_exp(t + 7,   P_IDLE,  3'd1, 1'b0);
        push_exp(t + 8,   P_COIN,  3'd1, 1'b1);
        push_exp(t + 17,  P_COIN,  3'd2, 1'b1);
        push_exp(t + 18,  P_IDLE,  3'd2, 1'b0);
        push_exp(t + 37,  P_IDLE,  3'd3, 1'b0);
        push_exp(t + 38,  P_START, 3'd3, 1'b1);
        push_exp(t + 47,  P_START, 3'd4, 1'b1);
        push_exp(t + 48,  P_FIRE,  3'd4, 1'b0);
        push_exp(t + 53,  P_IDLE,  3'd4, 1'b0);
        push_exp(t + 58,  P_FIRE,  3'd4, 1'b0);
        push_exp(t + 63,  P_IDLE,  3'd4, 1'b0);
        push_exp(t + 67,  P_FIRE,  3'd4, 1'b0);
        push_exp(t + 93,  P_IDLE,  3'd4, 1'b0);
        push_exp(t + 98,  P_FIRE,  3'd4, 1'b0);
        push_exp(t + 102, P_FIRE,  3'd0, 1'b0);
        push_exp(t + 103, P_IDLE,  3'd0, 1'b0);
        auto_en = 1'b1;
        wait_until(t + 60);
        button3 = 1'b1;
        wait_until(t + 81);
        button3 = 1'b0;
        wait_until(t + 95);
        auto_en = 1'b0;
        wait_until(t + 110);

        // abort during WAIT: no start pulse
        t = cyc;
        push_exp(t + 7,  P_IDLE, 3'd1, 1'b0);
        push_exp(t + 8,  P_COIN, 3'd1, 1'b1);
        push_exp(t + 17, P_COIN, 3'd2, 1'b1);
        push_exp(t + 18, P_IDLE, 3'd2, 1'b0);
        push_exp(t + 27, P_IDLE, 3'd0, 1'b0);
        auto_en = 1'b1;
        wait_until(t + 20);
        auto_en = 1'b0;
        wait_until(t + 50);

        // abort mid coin pulse: pulse still runs its full width
        t = cyc;
        push_exp(t + 7,  P_IDLE, 3'd1, 1'b0);
        push_exp(t + 8,  P_COIN, 3'd1, 1'b1);
        push_exp(t + 15, P_COIN, 3'd0, 1'b1);
        push_exp(t + 18, P_IDLE, 3'd0, 1'b0);
        auto_en = 1'b1;
        wait_until(t + 8);
        auto_en = 1'b0;
        wait_until(t + 30);

        // button1 press during the auto coin pulse
        t = cyc;
        push_exp(t + 7,  P_IDLE, 3'd1, 1'b0);
        push_exp(t + 8,  P_COIN, 3'd1, 1'b1);
        push_exp(t + 17, P_COIN, 3'd2, 1'b1);
        push_exp(t + 18, P_IDLE, 3'd2, 1'b0);
        push_exp(t + 27, P_IDLE, 3'd0, 1'b0);
        auto_en = 1'b1;
        wait_until(t + 5);
        button1 = 1'b1;
        wait_until(t + 15);
        button1 = 1'b0;
        wait_until(t + 20);
        auto_en = 1'b0;
        wait_until(t + 45);

        // asynchronous reset in the middle of a coin pulse
        t = cyc;
        push_exp(t + 8,  P_COIN, 3'd0, 1'b1);
        push_exp(t + 12, P_IDLE, 3'd0, 1'b0);
        button1 = 1'b1;
        wait_until(t + 10);
        button1 = 1'b0;
        wait_until(t + 12);
        reset_n = 1'b0;
        wait_until(t + 15);
        reset_n = 1'b1;
        wait_until(t + 30);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expected events never seen, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
